uart_rx_ctrl: RTL and testbench

UART receiver paired with the team's UART transmitter. It uses the same frame on the same line: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), idle high.
The block synchronises the asynchronous serial input and rejects start-bit glitches. It samples each bit at mid-period, checks the stop bit, and presents each received byte with a one-cycle valid pulse.
It sits between the board RX pin and any byte consumer, such as the loopback or command logic.

---
 rtl/uart_rx_ctrl.sv | 151 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 8N1 frames, 2-flop synchroniser with edge register, mid-bit sampling.
// Presents each well-framed byte with a one-cycle valid pulse; bad stop bits pulse rx_frame_err.
module uart_rx_ctrl #(
  parameter int CLK_PER   = 50_000_000,
  parameter int BAND_RATE = 9600
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int UART_CNT = CLK_PER / BAND_RATE;
  localparam int HALF_CNT = UART_CNT / 2;
  localparam int CNT_W    = (UART_CNT > 2) ? $clog2(UART_CNT) : 1;

  localparam logic [CNT_W-1:0] UART_LIM = CNT_W'(UART_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LIM = CNT_W'(HALF_CNT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic             rx_s1_q, rx_s2_q, rx_s3_q;
  logic             fall_s;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;

  // Synchroniser and edge register; all idle high so reset never looks like a start edge.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= uart_rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  assign fall_s = rx_s3_q & ~rx_s2_q;

  // Frame FSM: start is re-checked at half a bit so short glitches fall back to idle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d     = {CNT_W{1'b0}};
        bit_idx_d = 3'd0;
        if (fall_s) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LIM) begin
          cnt_d     = {CNT_W{1'b0}};
          bit_idx_d = 3'd0;
          if (!rx_s2_q) begin
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == UART_LIM) begin
          cnt_d              = {CNT_W{1'b0}};
          shift_d[bit_idx_q] = rx_s2_q;
          if (bit_idx_q == 3'd7) begin
            state_d   = S_STOP;
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == UART_LIM) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_IDLE;
          if (rx_s2_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = {CNT_W{1'b0}};
        bit_idx_d = 3'd0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_data       = data_q;
  assign rx_data_valid = valid_q;
  assign rx_frame_err  = ferr_q;
  assign rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl at 10 clocks per bit: frame-level model predicts every
// valid/error pulse (kind, byte, cycle) and compares with what the monitor sees.
module tb_uart_rx_ctrl;

  logic       clk_i;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_rx_ctrl #(.CLK_PER(1_000_000), .BAND_RATE(100_000)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .uart_rx(uart_rx), .rx_data(rx_data),
    .rx_data_valid(rx_data_valid), .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
  );

  localparam int BIT_CLKS = 10;
  // Pin falls at cycle n -> rx_s2 low at n+2 (D); valid at D+5+90+1.
  localparam int LATENCY  = 2 + 5 + 9 * BIT_CLKS + 1;

  typedef struct {
    int         kind;   // 1 = valid, 2 = frame error, 3 = both at once
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  int         cyc;
  int         n_chk;
  int         n_pass;
  logic [7:0] last_good;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Record every cycle in which a pulse output is high.
  always @(negedge clk_i) begin
    ev_t e;
    if (rst_n && (rx_data_valid || rx_frame_err)) begin
      e.kind = (rx_data_valid && rx_frame_err) ? 3 : (rx_data_valid ? 1 : 2);
      e.data = rx_data;
      e.cyc  = cyc;
      obs_q.push_back(e);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    ev_t e;
    e.cyc = cyc + LATENCY;
    if (stop_b) begin
      e.kind    = 1;
      e.data    = b;
      last_good = b;
    end else begin
      e.kind = 2;
      e.data = last_good;
    end
    exp_q.push_back(e);
    uart_rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk_i);
    for (int k = 0; k < 8; k++) begin
      uart_rx = b[k];
      repeat (BIT_CLKS) @(negedge clk_i);
    end
    uart_rx = stop_b;
    repeat (BIT_CLKS) @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic compare_events(input string tag);
    int n;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
      check({tag, "_data"}, {24'h0, obs_q[i].data}, {24'h0, exp_q[i].data});
      check({tag, "_cyc"}, obs_q[i].cyc, exp_q[i].cyc);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, {24'h0, rx_data}, 32'h0);
    check({tag, "_valid"}, {31'h0, rx_data_valid}, 32'h0);
    check({tag, "_ferr"}, {31'h0, rx_frame_err}, 32'h0);
    check({tag, "_busy"}, {31'h0, rx_busy}, 32'h0);
  endtask

  initial begin
    int         n;
    logic [7:0] b;
    logic       stop_b;
    cyc       = 0;
    n_chk     = 0;
    n_pass    = 0;
    last_good = 8'h00;
    uart_rx   = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(10);

    // 1: single frame
    send_frame(8'hA5, 1'b1);
    idle(20);
    compare_events("single");

    // 2: back-to-back frames
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(20);
    compare_events("b2b");

    // 3: start glitch, then a good frame
    n = cyc;
    uart_rx = 1'b0;
    repeat (3) @(negedge clk_i);
    uart_rx = 1'b1;
    @(negedge clk_i);
    check("glitch_busy_hi", {31'h0, rx_busy}, 32'h1);
    while (cyc < n + 8) @(negedge clk_i);
    check("glitch_busy_lo", {31'h0, rx_busy}, 32'h0);
    idle(20);
    send_frame(8'h5A, 1'b1);
    idle(20);
    compare_events("glitch");

    // 4: bad stop bit, then a good frame
    send_frame(8'h81, 1'b0);
    idle(BIT_CLKS);
    send_frame(8'h42, 1'b1);
    idle(20);
    compare_events("ferr");

    // 5: reset during data bit 4
    uart_rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk_i);
    b = 8'h6D;
    for (int k = 0; k < 4; k++) begin
      uart_rx = b[k];
      repeat (BIT_CLKS) @(negedge clk_i);
    end
    uart_rx = b[4];
    repeat (5) @(negedge clk_i);
    check("mid_busy", {31'h0, rx_busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    last_good = 8'h00;
    repeat (3) @(negedge clk_i);
    rst_n = 1'b1;
    idle(20);
    send_frame(8'hC3, 1'b1);
    idle(20);
    compare_events("reset");

    // 6: line stuck low for 300 clocks
    begin
      ev_t e;
      e.kind = 2;
      e.data = last_good;
      e.cyc  = cyc + LATENCY;
      exp_q.push_back(e);
    end
    uart_rx = 1'b0;
    repeat (300) @(negedge clk_i);
    idle(20);
    send_frame(8'h17, 1'b1);
    idle(20);
    compare_events("break");

    // Randomised frames with random gaps and occasional bad stop bits
    for (int i = 0; i < 12; i++) begin
      b      = 8'($urandom_range(0, 255));
      stop_b = ($urandom_range(0, 3) != 0);
      send_frame(b, stop_b);
      if (!stop_b) begin
        idle(BIT_CLKS + $urandom_range(0, 7));
      end else if ($urandom_range(0, 1) == 1) begin
        idle($urandom_range(1, 15));
      end
    end
    idle(20);
    compare_events("random");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
